// File: rtl/escrita_dado_pkg.sv
// escrita_dado_pkg: shared definitions for the escrita_dado_mem store engine.
//   - store size encodings carried on the size input
//   - FSM state enumeration
//   - helper returning the number of byte-lane address bits for a word width
package escrita_dado_pkg;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_MERGE = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    // Address bits that select a byte inside one data word.
    function automatic int lane_bits(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/fusao_bytes.sv
// fusao_bytes: combinational little-endian lane merge for sub-word stores.
// Ports:
//   old_i   - word previously read from memory
//   data_i  - store source; only its low 8/16 bits are used for byte/half
//   lane_i  - byte lane (address low bits) of the store
//   size_i  - SZ_WORD / SZ_HALF / SZ_BYTE
//   word_o  - old word with the target lane(s) replaced
module fusao_bytes
    import escrita_dado_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LANE_W = lane_bits(DATA_W)
) (
    input  logic [DATA_W-1:0] old_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [LANE_W-1:0] lane_i,
    input  logic [1:0]        size_i,
    output logic [DATA_W-1:0] word_o
);

    always_comb begin
        word_o = old_i;
        if (size_i == SZ_WORD)
            word_o = data_i;
        else if (size_i == SZ_HALF)
            word_o[int'(lane_i >> 1) * 16 +: 16] = data_i[15:0];
        else if (size_i == SZ_BYTE)
            word_o[int'(lane_i) * 8 +: 8] = data_i[7:0];
    end

endmodule

// File: rtl/escrita_dado_mem.sv
// escrita_dado_mem: store engine writing one of N_SRC data sources to memory.
// Word stores go straight to a write; halfword/byte stores do a
// read-modify-write (READ, MERGE, WRITE) when ESCRITA_DADO_RMW_EN is defined,
// and are rejected with err when it is not.
// Ports:
//   clk, reset           - clock, synchronous active-low reset
//   start, sel, src_data - store request, source select, packed sources
//   addr, size           - byte address and store size
//   busy, done, err      - status (done/err are one-cycle pulses)
//   mem_req, mem_we, mem_addr, mem_wdata, mem_rdata, mem_ready - memory port
module escrita_dado_mem
    import escrita_dado_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int N_SRC  = 3,
    parameter int ADDR_W = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [$clog2(N_SRC)-1:0]  sel,
    input  logic [N_SRC*DATA_W-1:0]   src_data,
    input  logic [ADDR_W-1:0]         addr,
    input  logic [1:0]                size,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic [DATA_W-1:0]         mem_rdata,
    input  logic                      mem_ready
);

    localparam int LANE_W = lane_bits(DATA_W);

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [1:0]          size_q, size_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                req_q, req_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   maddr_q, maddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;

    logic [DATA_W-1:0]   sel_word;
    logic                bad_req;
    logic                sub_bad;
    logic [DATA_W-1:0]   fu_data;
    logic [LANE_W-1:0]   fu_lane;
    logic [1:0]          fu_size;
    logic [DATA_W-1:0]   merged;
    logic                ack;

    // Decoded source; an out-of-range sel yields zero and is rejected anyway.
    always_comb begin
        sel_word = '0;
        for (int k = 0; k < N_SRC; k++)
            if (int'(sel) == k) sel_word = src_data[k*DATA_W +: DATA_W];
    end

`ifdef ESCRITA_DADO_RMW_EN
    assign sub_bad = (size == SZ_HALF) && addr[0];
`else
    assign sub_bad = (size == SZ_HALF) || (size == SZ_BYTE);
    logic unused_rdata;
    assign unused_rdata = ^mem_rdata;
`endif

    assign bad_req = (int'(sel) >= N_SRC) || (size == SZ_RSVD) || sub_bad ||
                     ((size == SZ_WORD) && (addr[LANE_W-1:0] != '0));

    // A ready seen while no request is outstanding must not advance the FSM.
    assign ack = req_q && mem_ready;

    // The merge unit is shared: in IDLE it passes the new source through for
    // word stores; in MERGE it splices the latched source into the read word.
    fusao_bytes #(.DATA_W(DATA_W), .LANE_W(LANE_W)) u_fusao (
        .old_i  (rdata_q),
        .data_i (fu_data),
        .lane_i (fu_lane),
        .size_i (fu_size),
        .word_o (merged)
    );

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        addr_d  = addr_q;
        size_d  = size_q;
        rdata_d = rdata_q;
        req_d   = req_q;
        we_d    = we_q;
        maddr_d = maddr_q;
        wdata_d = wdata_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        fu_data = data_q;
        fu_lane = addr_q[LANE_W-1:0];
        fu_size = size_q;
        case (state_q)
            S_IDLE: begin
                fu_data = sel_word;
                fu_lane = addr[LANE_W-1:0];
                fu_size = size;
                if (start && bad_req) begin
                    err_d = 1'b1;
                end else if (start) begin
                    data_d  = sel_word;
                    addr_d  = addr;
                    size_d  = size;
                    req_d   = 1'b1;
                    we_d    = (size == SZ_WORD);
                    maddr_d = {addr[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
                    wdata_d = (size == SZ_WORD) ? merged : wdata_q;
                    state_d = (size == SZ_WORD) ? S_WRITE : S_READ;
                end
            end
`ifdef ESCRITA_DADO_RMW_EN
            S_READ: begin
                if (ack) begin
                    rdata_d = mem_rdata;
                    req_d   = 1'b0;
                    state_d = S_MERGE;
                end
            end
            S_MERGE: begin
                wdata_d = merged;
                req_d   = 1'b1;
                we_d    = 1'b1;
                state_d = S_WRITE;
            end
`endif
            S_WRITE: begin
                if (ack) begin
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            addr_q  <= '0;
            size_q  <= '0;
            rdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            maddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            rdata_q <= rdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            req_q   <= req_d;
            we_q    <= we_d;
            maddr_q <= maddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = maddr_q;
    assign mem_wdata = wdata_q;

endmodule
